// File: rtl/ps2_kbmatrix_pkg.sv
// Shared types and constants for the PS/2 to Z88 key matrix decoder.
package ps2_kbmatrix_pkg;

  localparam int unsigned MAT_W    = 64;
  localparam int unsigned IDX_W    = 6;
  localparam int unsigned SKIP_LEN = 7;
  localparam int unsigned SKIP_W   = 3;

  localparam logic [7:0] CODE_E0 = 8'hE0;
  localparam logic [7:0] CODE_F0 = 8'hF0;
  localparam logic [7:0] CODE_E1 = 8'hE1;
  localparam logic [7:0] CODE_AA = 8'hAA;
  localparam logic [7:0] CODE_FC = 8'hFC;
  localparam logic [7:0] CODE_FA = 8'hFA;
  localparam logic [7:0] CODE_EE = 8'hEE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_SKIP
  } state_t;

endpackage

// File: rtl/ps2_kbmatrix_keymap.sv
// Combinational scancode lookup: {ext,code} -> Z88 matrix index (row*8+col).
module ps2_keymap (
  input  logic [8:0] key,
  output logic [5:0] idx,
  output logic       hit
);

  always_comb begin
    idx = 6'd0;
    hit = 1'b1;
    unique case (key)
      9'h01C: idx = 6'd29;  // A
      9'h01B: idx = 6'd28;  // S
      9'h023: idx = 6'd27;  // D
      9'h02B: idx = 6'd26;  // F
      9'h015: idx = 6'd21;  // Q
      9'h01D: idx = 6'd20;  // W
      9'h024: idx = 6'd19;  // E
      9'h05A: idx = 6'd6;   // Enter
      9'h029: idx = 6'd5;   // Space
      9'h066: idx = 6'd7;   // Delete
      9'h076: idx = 6'd61;  // Escape
      9'h00D: idx = 6'd53;  // Tab
      9'h012: idx = 6'd55;  // both shifts share one matrix position
      9'h059: idx = 6'd55;
      9'h175: idx = 6'd3;   // cursor up
      9'h172: idx = 6'd4;   // cursor down
      9'h16B: idx = 6'd2;   // cursor left
      9'h174: idx = 6'd1;   // cursor right
      default: hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/ps2_kbmatrix.sv
// PS/2 scancode decoder driving a 64-bit active-low Z88 key matrix.
// Optional KBD_DEBUG_EN exposes the last received byte on kbdval.
module ps2_kbmatrix
  import ps2_kbmatrix_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        code_valid,
  input  logic [7:0]  code,
  input  logic        flush,
  output logic [63:0] kbmat_out
`ifdef KBD_DEBUG_EN
  ,
  output logic [7:0]  kbdval
`endif
);

  state_t              state_q, state_d;
  logic [SKIP_W-1:0]   skip_q, skip_d;
  logic [MAT_W-1:0]    kbmat_q, kbmat_d;
  logic                ext_c, make_c, brk_c;
  logic [IDX_W-1:0]    idx_c;
  logic                hit_c;

  ps2_keymap u_keymap (
    .key (9'({ext_c, code})),
    .idx (idx_c),
    .hit (hit_c)
  );

  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    kbmat_d = kbmat_q;
    ext_c   = 1'b0;
    make_c  = 1'b0;
    brk_c   = 1'b0;
    if (flush) begin
      // flush wins over a same-cycle byte, which is dropped
      state_d = ST_IDLE;
      skip_d  = '0;
      kbmat_d = '1;
    end else if (code_valid) begin
      unique case (state_q)
        ST_IDLE: begin
          if (code == CODE_E0) begin
            state_d = ST_EXT;
          end else if (code == CODE_F0) begin
            state_d = ST_BRK;
          end else if (code == CODE_E1) begin
            state_d = ST_SKIP;
            skip_d  = SKIP_W'(SKIP_LEN);
          end else if (code == CODE_AA || code == CODE_FC) begin
            kbmat_d = '1;
          end else if (code != CODE_FA && code != CODE_EE) begin
            make_c = 1'b1;
          end
        end
        ST_EXT: begin
          if (code == CODE_F0) begin
            state_d = ST_EXT_BRK;
          end else begin
            ext_c   = 1'b1;
            make_c  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_BRK: begin
          brk_c   = 1'b1;
          state_d = ST_IDLE;
        end
        ST_EXT_BRK: begin
          ext_c   = 1'b1;
          brk_c   = 1'b1;
          state_d = ST_IDLE;
        end
        ST_SKIP: begin
          skip_d = skip_q - SKIP_W'(1);
          if (skip_q <= SKIP_W'(1)) begin
            skip_d  = '0;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
      if (hit_c && make_c) kbmat_d[idx_c] = 1'b0;
      if (hit_c && brk_c)  kbmat_d[idx_c] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      skip_q  <= '0;
      kbmat_q <= '1;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      kbmat_q <= kbmat_d;
    end
  end

  assign kbmat_out = kbmat_q;

`ifdef KBD_DEBUG_EN
  logic [7:0] kbdval_q, kbdval_d;

  always_comb begin
    kbdval_d = kbdval_q;
    if (code_valid) kbdval_d = code;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) kbdval_q <= 8'h00;
    else          kbdval_q <= kbdval_d;
  end

  assign kbdval = kbdval_q;
`endif

endmodule

// File: tb/tb_ps2_kbmatrix.sv
// Directed table-driven bench for ps2_kbmatrix (optionally with KBD_DEBUG_EN).
module tb_ps2_kbmatrix;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        code_valid;
  logic [7:0]  code;
  logic        flush;
  logic [63:0] kbmat_out;
`ifdef KBD_DEBUG_EN
  logic [7:0]  kbdval;
`endif

  ps2_kbmatrix dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .code_valid (code_valid),
    .code       (code),
    .flush      (flush),
    .kbmat_out  (kbmat_out)
`ifdef KBD_DEBUG_EN
    ,
    .kbdval     (kbdval)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        cv;
    logic [7:0]  code;
    logic        fl;
    logic [63:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [63:0] clr(input int b);
    logic [63:0] m;
    m = '1;
    if (b >= 0) m[b] = 1'b0;
    return m;
  endfunction

  task automatic add(input logic cv, input logic [7:0] c, input logic fl,
                     input logic [63:0] e, input string n);
    vec_t v;
    v.cv = cv; v.code = c; v.fl = fl; v.exp = e; v.name = n;
    vecs.push_back(v);
  endtask

  task automatic check(input string n, input logic [63:0] exp);
    total++;
    if (kbmat_out !== exp) begin
      bad++;
      $display("FAIL %s: kbmat_out=%h expected=%h", n, kbmat_out, exp);
    end
  endtask

  // drive one cycle of inputs, then sample just after the capturing edge
  task automatic step(input logic cv, input logic [7:0] c, input logic fl);
    code_valid = cv; code = c; flush = fl;
    @(posedge clk);
    #1;
  endtask

  localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    reset_n = 1'b0; code_valid = 1'b0; code = 8'h00; flush = 1'b0;

    add(1, 8'h1C, 0, clr(29), "make_a");
    add(1, 8'hF0, 0, clr(29), "brk_prefix");
    add(1, 8'h1C, 0, ALL1,    "break_a");
    add(1, 8'hE0, 0, ALL1,    "ext_prefix");
    add(1, 8'h75, 0, clr(3),  "make_up");
    add(1, 8'hE0, 0, clr(3),  "ext_prefix2");
    add(1, 8'hF0, 0, clr(3),  "ext_brk_prefix");
    add(1, 8'h75, 0, ALL1,    "break_up");
    add(1, 8'h75, 0, ALL1,    "unmapped_75");
    add(1, 8'h12, 0, clr(55), "make_lshift");
    add(1, 8'h59, 0, clr(55), "make_rshift");
    add(1, 8'hF0, 0, clr(55), "brk_prefix3");
    add(1, 8'h12, 0, ALL1,    "break_shared");
    add(1, 8'h1C, 0, clr(29), "make_a2");
    add(1, 8'h1C, 0, clr(29), "typematic");
    add(1, 8'hAA, 0, ALL1,    "bat_aa");
    add(1, 8'h1C, 0, clr(29), "make_a3");
    add(1, 8'hFA, 0, clr(29), "ignore_fa");
    add(1, 8'hEE, 0, clr(29), "ignore_ee");
    add(0, 8'hF0, 0, clr(29), "no_valid");
    add(1, 8'h1C, 0, clr(29), "still_idle");
    add(1, 8'hFC, 0, ALL1,    "bat_fc");
    add(1, 8'hE1, 0, ALL1,    "pause_e1");
    add(1, 8'h14, 0, ALL1,    "pause_1");
    add(1, 8'h77, 0, ALL1,    "pause_2");
    add(1, 8'hE1, 0, ALL1,    "pause_3");
    add(1, 8'hF0, 0, ALL1,    "pause_4");
    add(1, 8'h14, 0, ALL1,    "pause_5");
    add(1, 8'hF0, 0, ALL1,    "pause_6");
    add(1, 8'h77, 0, ALL1,    "pause_7");
    add(1, 8'h5A, 0, clr(6),  "enter_after_pause");
    add(0, 8'h00, 1, ALL1,    "flush_idle");
    add(1, 8'hE0, 0, ALL1,    "ext_before_flush");
    add(0, 8'h00, 1, ALL1,    "flush_mid_seq");
    add(1, 8'h1C, 0, clr(29), "make_after_flush");
    add(1, 8'h5A, 1, ALL1,    "flush_beats_strobe");
    add(0, 8'h00, 0, ALL1,    "dropped_byte");
    add(1, 8'hE0, 0, ALL1,    "ext_unmapped_pre");
    add(1, 8'h12, 0, ALL1,    "ext_unmapped");
    add(1, 8'h5A, 0, clr(6),  "idle_after_unmapped");

    // reset state, checked while reset is held
    repeat (2) @(posedge clk);
    #1;
    check("reset_value", ALL1);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      step(vecs[i].cv, vecs[i].code, vecs[i].fl);
      check(vecs[i].name, vecs[i].exp);
    end

    // reset in the middle of E0 F0 discards the partial break
    step(0, 8'h00, 1);
    step(1, 8'hE0, 0);
    step(1, 8'hF0, 0);
    code_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1 check("async_reset", ALL1);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    step(1, 8'h1C, 0);
    check("make_after_reset", clr(29));

    // output must not change before the capturing edge
    @(negedge clk);
    code_valid = 1'b1; code = 8'h5A;
    #2 check("no_early_update", clr(29));
    @(posedge clk);
    #1 check("one_cycle_latency", clr(29) & clr(6));

`ifdef KBD_DEBUG_EN
    step(1, 8'hE0, 0);
    step(1, 8'h75, 0);
    total++;
    if (kbdval !== 8'h75) begin
      bad++;
      $display("FAIL kbdval: kbdval=%h expected=75", kbdval);
    end
`endif

    code_valid = 1'b0;
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_kbmatrix.md
PS2_KBMATRIX -- requirements
Module: ps2_kbmatrix

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock, the master clock; all logic on the rising edge.
REQ-002 SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-003 SHALL have port code_valid, input, 1 bit: one-cycle strobe marking a received PS/2 byte.
REQ-004 SHALL have port code, input, 8 bits: scancode byte, valid when code_valid=1.
REQ-005 SHALL have port flush, input, 1 bit: synchronous release of all keys.
REQ-006 SHALL have port kbmat_out, output, 64 bits: Z88 key matrix, index = row*8+col, 0 = pressed.
REQ-007 SHALL have port kbdval, output, 8 bits, present only under KBD_DEBUG_EN: last accepted byte.

Function
REQ-008 SHALL decode bytes with FSM states IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0), SKIP (E1 Pause sequence).
REQ-009 IDLE: E0->EXT, F0->BRK, E1->SKIP with skip counter=7, any other byte handled as make with ext=0, stay IDLE.
REQ-010 EXT: F0->EXT_BRK, otherwise make with ext=1 then IDLE.
REQ-011 BRK: break with ext=0 then IDLE; EXT_BRK: break with ext=1 then IDLE.
REQ-012 SKIP: decrement counter per code_valid; return to IDLE when the 7th byte is consumed; no matrix change.
REQ-013 Make SHALL clear kbmat_out[idx]; break SHALL set kbmat_out[idx]; idx from lookup of {ext,code}.
REQ-014 Unmapped {ext,code} SHALL leave kbmat_out unchanged and still return FSM to IDLE.
REQ-015 Fixed anchor mappings: {0,1C}->29, {0,5A}->6, {1,75}->3, {0,12}->55, {0,59}->55 (both shifts share bit 55).
REQ-016 kbmat_out SHALL update on the clock edge that samples code_valid of the final byte (latency 1 cycle to output).
REQ-017 Bytes AA (BAT pass) and FC (BAT fail) in IDLE SHALL set all 64 bits to 1; FA and EE in IDLE SHALL be ignored.
REQ-018 Repeated make of a held key (typematic) SHALL be idempotent.
REQ-019 flush=1 SHALL set all bits to 1 and force FSM to IDLE; flush has priority over a simultaneous code_valid, and that byte is dropped.
REQ-020 code SHALL be ignored when code_valid=0; code_valid held high SHALL be treated as one byte per cycle.

Reset
REQ-021 On reset_n=0: kbmat_out=64'hFFFF_FFFF_FFFF_FFFF, FSM=IDLE, skip counter=0, kbdval=8'h00; takes effect asynchronously, release synchronous to clk.
REQ-022 Reset asserted mid-sequence (e.g. after E0 F0) SHALL discard the partial sequence; the next byte is decoded from IDLE.

Configuration
REQ-023 Macro KBD_DEBUG_EN SHALL gate kbdval: when defined, kbdval register loads code on every code_valid (including prefixes and skipped bytes), so it can drive the HEX displays; when undefined, port and register absent, behaviour otherwise identical.

Structure
REQ-024 Shared package SHALL hold FSM state typedef, prefix constants (E0, F0, E1, AA, FC, FA, EE), skip length 7, and matrix width 64.
REQ-025 Scancode lookup SHALL be sub-module ps2_keymap: combinational, input {ext,code} (9 bits), outputs idx (6 bits) and hit (1 bit).
REQ-026 Matrix register and FSM SHALL reside in ps2_kbmatrix.

Verification
REQ-027 Bytes 1C -> kbmat_out[29]=0 one cycle after strobe; then F0,1C -> bit 29=1, all others 1.
REQ-028 Bytes E0,75 -> bit 3=0; E0,F0,75 -> bit 3=1; bare 75 with no mapping for {0,75} -> no change.
REQ-029 Press 12 and 59, release 12 -> bit 55=1 (shared bit released); press 1C, then AA -> all 64 bits 1.
REQ-030 E1,14,77,E1,F0,14,F0,77 then 5A -> only bit 6=0 (Pause fully skipped, 5A decoded from IDLE).
REQ-031 E0,F0 then reset_n pulse then 1C -> bit 29=0 (make, not break); flush on the same cycle as a 5A strobe -> bit 6 stays 1.
REQ-032 With KBD_DEBUG_EN: bytes E0,75 -> kbdval=8'h75; without it: build with no kbdval port, REQ-027 passes.
